uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for the SoC peripheral subsystem. It de-serialises an asynchronous RS-232-style line into words of configurable width, using the shared baud-generator oversampling tick. It adds start-bit validation, optional parity checking, 1 or 2 stop bits, framing and break detection, and a held output register. It replaces the fixed 8N1 receiver behind the APB/AHB UART wrapper.

## Interface
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- OVERSAMPLE, 16: b_tick pulses per bit period; must be even and at least 8.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- clk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- b_tick  input  1  single-clk pulse from the baud generator, OVERSAMPLE per bit.
- rx  input  1  asynchronous serial line; idle high.
- parity_odd  input  1  selects odd parity when 1, even when 0 (present only with UART_RX_PARITY_EN).
- rx_done  output  1  one-clk pulse: frame complete; dout and flags updated.
- dout  output  DATA_BITS  last received word, LSB first on the line.
- frame_err  output  1  a stop bit of the last frame was sampled 0.
- parity_err  output  1  parity mismatch in the last frame (tied 0 without the macro).
- break_det  output  1  last frame was all-zero, including parity and stop bits.
- busy  output  1  receiver is not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser; the flops reset to 1. A start is a falling edge of the synchronised line, compared against a registered previous value.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: on a detected falling edge -> START, with the tick counter cleared. A line held low never triggers a start; it must return high first.
- START: count b_tick pulses. At tick OVERSAMPLE/2, sample the line:
  - low -> DATA, with the counter and bit index cleared;
  - high -> false start, back to IDLE with no flags and no rx_done.
- DATA: sample every OVERSAMPLE ticks and shift the sample into the MSB of the shift register. After DATA_BITS samples -> PARITY if compiled in, else STOP.
- PARITY: sample after OVERSAMPLE ticks. Error if XOR of the data bits, the parity bit and parity_odd is not 0 (odd = total ones including the parity bit is odd).
- STOP: sample every OVERSAMPLE ticks, STOP_BITS times. Any 0 sample sets the frame error. After the last stop sample, go to IDLE and pulse rx_done. There is no wait for the end of the stop bit, so the receiver can resync half a bit early.
- On rx_done, dout, frame_err, parity_err and break_det load together and hold until the next rx_done. rx_done fires even when the frame is in error.
- break_det = every sampled bit of the frame is 0. A break always implies frame_err.
- The tick counter is $clog2(OVERSAMPLE) bits wide and the bit index is $clog2(DATA_BITS+1) bits wide. Neither counter wraps inside a state; both clear on every state transition.

## Timing
- Reset values: rx_done=0, dout=0, frame_err=0, parity_err=0, break_det=0, busy=0. State is IDLE and the synchroniser is all-ones.
- Reset mid-frame aborts the frame: no rx_done, and the outputs return to their reset values.
- Latency from a line edge to a visible edge is 2 clk (synchroniser) plus 1 clk (edge register).
- rx_done is high for exactly one clk, in the cycle after the clk edge on which the last stop-bit sample is taken. Outputs change on that same edge.
- With b_tick low, all counters hold.
- With b_tick high every clk, one bit period equals OVERSAMPLE clk cycles.
- No backpressure: the consumer must read dout before the next rx_done, which is at least (1+DATA_BITS+STOP_BITS) bit periods away.

## Configuration
- UART_RX_PARITY_EN defined: the parity_odd port, the PARITY state and the parity_err logic are present, and a frame carries one parity bit.
- UART_RX_PARITY_EN undefined: no parity bit in the frame, no parity_odd port, and parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for the legal parameter limits;
  - a function computing the counter widths.
- Sub-module uart_rx_sync holds the 2-flop synchroniser plus the falling-edge detector. Its outputs are rx_s and rx_fall.

## Test plan
- 8N1, OVERSAMPLE=16, b_tick every clk, send 0xA5 -> one rx_done; dout=0xA5; frame_err, parity_err and break_det all 0.
- Low glitch of 4 ticks on an idle line -> no rx_done; busy rises, then returns to 0 within 8 ticks.
- Send 0x3C with the stop bit driven 0 -> rx_done; dout=0x3C, frame_err=1, break_det=0.
- Line held low for 20 bit times, then high, then a valid 0x11 -> first rx_done with dout=0x00, break_det=1 and frame_err=1. No further frame during the low period. Second rx_done has dout=0x11 and clean flags.
- UART_RX_PARITY_EN, parity_odd=0, send 0x07 with parity bit 0 -> parity_err=1. Resend with parity bit 1 -> parity_err=0.
- DATA_BITS=7, STOP_BITS=2, send 0x55 with the second stop bit 0 -> dout=7'h55, frame_err=1. Assert resetn low during the data bits of the next frame -> no rx_done, all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, legal parameter limits and counter sizing for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    // Width of a counter holding values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the serial line plus a falling-edge detector.
// Every flop resets high so an idle line never produces a spurious edge.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);
    logic [1:0] sync_q;
    logic       prev_q;

    // Metastability chain followed by the previous-value register for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            prev_q <= sync_q[1];
        end
    end

    assign rx_s    = sync_q[1];
    assign rx_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable word width and stop bits.
// Optional parity bit and checking: define UART_RX_PARITY_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 b_tick,
    input  logic                 rx,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        OVERSAMPLE < OVERSAMPLE_MIN || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
        $error("uart_rx_cfg: illegal parameter set");
    end

    logic rx_s, rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e            state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 ferr_acc_q;   // a stop sample before the last one was 0
    logic                 ones_q;       // some sampled bit of this frame was 1
    logic                 rx_done_q;
    logic                 frame_err_q;
    logic                 break_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_acc_q;
    logic                 parity_err_q;
`endif

    // Tick that lands mid start bit, and tick that closes a full bit period.
    logic tick_mid_d, tick_bit_d;
    assign tick_mid_d = b_tick && (tick_q == TICK_MID);
    assign tick_bit_d = b_tick && (tick_q == TICK_LAST);

    // Frame FSM: counts ticks, samples bits and loads the held result registers on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            ferr_acc_q  <= 1'b0;
            ones_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_fall) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (tick_mid_d) begin
                        tick_q <= '0;
                        idx_q  <= '0;
                        if (!rx_s) begin
                            state_q    <= DATA;
                            ferr_acc_q <= 1'b0;
                            ones_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;    // false start, nothing reported
                        end
                    end else if (b_tick) begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_bit_d) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        ones_q  <= ones_q | rx_s;
                        tick_q  <= '0;
                        if (idx_q == DATA_LAST) begin
                            idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (b_tick) begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_bit_d) begin
                        perr_acc_q <= (^shift_q) ^ rx_s ^ parity_odd;
                        ones_q     <= ones_q | rx_s;
                        tick_q     <= '0;
                        idx_q      <= '0;
                        state_q    <= STOP;
                    end else if (b_tick) begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_bit_d) begin
                        tick_q <= '0;
                        if (idx_q == STOP_LAST) begin
                            // Finish mid stop bit so the next start edge is never missed.
                            state_q     <= IDLE;
                            idx_q       <= '0;
                            rx_done_q   <= 1'b1;
                            dout_q      <= shift_q;
                            frame_err_q <= ferr_acc_q | ~rx_s;
                            break_q     <= ~(ones_q | rx_s);
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= perr_acc_q;
`endif
                        end else begin
                            ferr_acc_q <= ferr_acc_q | ~rx_s;
                            ones_q     <= ones_q | rx_s;
                            idx_q      <= idx_q + 1'b1;
                        end
                    end else if (b_tick) begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_done   = rx_done_q;
    assign dout      = dout_q;
    assign frame_err = frame_err_q;
    assign break_det = break_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: drives two receivers (8N1/OS16 and 7-bit, 2 stop, OS8) with
// directed and random frames; a frame-level model predicts every rx_done.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int DB0 = 8, OS0 = 16, SB0 = 1;
    localparam int DB1 = 7, OS1 = 8,  SB1 = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
        logic       brk;
        int         done_cyc;   // exact completion cycle, -1 when ticks are gated
        int         deadline;
    } exp_t;

    logic clk, rstn0, rstn1, b_tick, rx0, rx1, po;
    logic           done0, fe0, pe0, bk0, bz0;
    logic [DB0-1:0] dout0;
    logic           done1, fe1, pe1, bk1, bz1;
    logic [DB1-1:0] dout1;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   div   = 1;
    exp_t q0[$];
    exp_t q1[$];
    exp_t held[2];

    uart_rx_cfg #(.DATA_BITS(DB0), .OVERSAMPLE(OS0), .STOP_BITS(SB0)) dut0 (
        .clk(clk), .resetn(rstn0), .b_tick(b_tick), .rx(rx0),
`ifdef UART_RX_PARITY_EN
        .parity_odd(po),
`endif
        .rx_done(done0), .dout(dout0), .frame_err(fe0), .parity_err(pe0),
        .break_det(bk0), .busy(bz0)
    );

    uart_rx_cfg #(.DATA_BITS(DB1), .OVERSAMPLE(OS1), .STOP_BITS(SB1)) dut1 (
        .clk(clk), .resetn(rstn1), .b_tick(b_tick), .rx(rx1),
`ifdef UART_RX_PARITY_EN
        .parity_odd(po),
`endif
        .rx_done(done1), .dout(dout1), .frame_err(fe1), .parity_err(pe1),
        .break_det(bk1), .busy(bz1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: every clk when div==1, else one clk in div.
    initial begin
        int tc;
        tc = 0;
        b_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tc = (tc + 1) % div;
            b_tick = (div == 1) || (tc == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    function automatic exp_t zero_exp();
        exp_t z;
        z.data = '0; z.ferr = 1'b0; z.perr = 1'b0; z.brk = 1'b0;
        z.done_cyc = 0; z.deadline = 0;
        return z;
    endfunction

    // Per-cycle comparison of one DUT against the scoreboard.
    task automatic chk(input int d, input logic rn, input logic done, input logic [8:0] dq,
                       input logic fe, input logic pe, input logic bk, input logic bz);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (!rn) begin
            tests++;
            if (done || dq != 9'd0 || fe || pe || bk || bz) begin
                fails++;
                $display("FAIL reset_outputs dut%0d cyc %0d: got done=%b dout=%0h fe=%b pe=%b brk=%b busy=%b, need all 0",
                         d, cyc, done, dq, fe, pe, bk, bz);
            end
            held[d] = zero_exp();
            return;
        end
        e = zero_exp();
        if (n > 0) begin
            if (d == 0) e = q0[0]; else e = q1[0];
        end
        if (done) begin
            tests++;
            if (n == 0) begin
                fails++;
                $display("FAIL unexpected_done dut%0d cyc %0d: dout=%0h fe=%b brk=%b", d, cyc, dq, fe, bk);
                held[d].data = dq; held[d].ferr = fe; held[d].perr = pe; held[d].brk = bk;
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                if ((e.done_cyc >= 0 && e.done_cyc != cyc) || dq != e.data || fe != e.ferr ||
                    pe != e.perr || bk != e.brk || bz) begin
                    fails++;
                    $display("FAIL frame dut%0d: got cyc=%0d dout=%0h fe=%b pe=%b brk=%b busy=%b, need cyc=%0d dout=%0h fe=%b pe=%b brk=%b busy=0",
                             d, cyc, dq, fe, pe, bk, bz, e.done_cyc, e.data, e.ferr, e.perr, e.brk);
                end
                held[d] = e;
            end
        end else begin
            tests++;
            if (dq != held[d].data || fe != held[d].ferr || pe != held[d].perr || bk != held[d].brk) begin
                fails++;
                $display("FAIL hold dut%0d cyc %0d: got dout=%0h fe=%b pe=%b brk=%b, need dout=%0h fe=%b pe=%b brk=%b",
                         d, cyc, dq, fe, pe, bk, held[d].data, held[d].ferr, held[d].perr, held[d].brk);
                held[d].data = dq; held[d].ferr = fe; held[d].perr = pe; held[d].brk = bk;
            end
            if (n > 0 && cyc > e.deadline) begin
                tests++;
                fails++;
                $display("FAIL missed_done dut%0d cyc %0d: no rx_done, need dout=%0h by cyc %0d",
                         d, cyc, e.data, e.deadline);
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            end
        end
    endtask

    always @(negedge clk) begin
        chk(0, rstn0, done0, {1'b0, dout0}, fe0, pe0, bk0, bz0);
        chk(1, rstn1, done1, {2'b0, dout1}, fe1, pe1, bk1, bz1);
    end

    task automatic lit(input string name, input logic [8:0] got, input logic [8:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, need %0h", name, got, want);
        end
    endtask

    // Hold a line level for n clks; returns aligned just after a rising edge.
    task automatic drive(input int d, input logic v, input int n);
        if (d == 0) rx0 = v; else rx1 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Build a frame as a list of line levels, predict the result, then send it.
    task automatic send_frame(input int d, input logic [8:0] data, input logic pflip,
                              input logic [1:0] stops, input int gap);
        int         db, os, sb, k, bclk;
        logic       lv[0:15];
        logic [8:0] dm;
        exp_t       e;
        db   = (d == 0) ? DB0 : DB1;
        os   = (d == 0) ? OS0 : OS1;
        sb   = (d == 0) ? SB0 : SB1;
        bclk = os * div;
        dm   = '0;
        for (int i = 0; i < db; i++) dm[i] = data[i];
        lv[0] = 1'b0;
        for (int i = 0; i < db; i++) lv[1 + i] = dm[i];
        k = 1 + db;
        if (PB == 1) begin
            lv[k] = (^dm) ^ po ^ pflip;
            k++;
        end
        for (int i = 0; i < sb; i++) begin
            lv[k] = stops[i];
            k++;
        end
        e = zero_exp();
        e.data = dm;
        e.brk  = 1'b1;
        for (int i = 0; i < k; i++) if (lv[i]) e.brk = 1'b0;
        for (int i = k - sb; i < k; i++) if (!lv[i]) e.ferr = 1'b1;
        if (PB == 1) e.perr = (^dm) ^ lv[1 + db] ^ po;
        e.done_cyc = (div == 1) ? cyc + 3 + os / 2 + os * (k - 1) : -1;
        e.deadline = cyc + bclk * k + 10;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        for (int i = 0; i < k; i++) drive(d, lv[i], bclk);
        drive(d, 1'b1, gap);
    endtask

    initial begin
        logic [8:0] rd;
        logic [1:0] rs;
        exp_t       e;
        rstn0 = 1'b0; rstn1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1; po = 1'b0;
        held[0] = zero_exp(); held[1] = zero_exp();
        repeat (5) @(posedge clk);
        #1;
        rstn0 = 1'b1; rstn1 = 1'b1;
        drive(0, 1'b1, 8);

        // Clean 8N1 frame
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 2 * OS0);
        lit("a5_dout", 9'(dout0), 9'h0A5);
        lit("a5_flags", 9'({fe0, pe0, bk0}), 9'd0);

        // Four-tick low glitch: start validation must reject it
        rx0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("glitch_busy_rise", 9'(bz0), 9'd1);
        @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (OS0 / 2 - 1) @(posedge clk);
        @(negedge clk);
        lit("glitch_busy_fall", 9'(bz0), 9'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 2 * OS0);

        // Stop bit driven low
        send_frame(0, 9'h03C, 1'b0, 2'b00, 2 * OS0);
        lit("stop0_dout", 9'(dout0), 9'h03C);
        lit("stop0_ferr", 9'(fe0), 9'd1);
        lit("stop0_brk", 9'(bk0), 9'd0);

        // Break: line low for 20 bit times gives exactly one all-zero frame
        e = zero_exp();
        e.ferr = 1'b1; e.brk = 1'b1; e.perr = (PB == 1) ? po : 1'b0;
        e.done_cyc = cyc + 3 + OS0 / 2 + OS0 * (DB0 + PB + SB0);
        e.deadline = e.done_cyc + 2;
        q0.push_back(e);
        drive(0, 1'b0, 20 * OS0);
        lit("break_dout", 9'(dout0), 9'h000);
        lit("break_brk", 9'(bk0), 9'd1);
        lit("break_ferr", 9'(fe0), 9'd1);
        drive(0, 1'b1, 2 * OS0);
        send_frame(0, 9'h011, 1'b0, 2'b11, 2 * OS0);
        lit("after_break_dout", 9'(dout0), 9'h011);
        lit("after_break_flags", 9'({fe0, pe0, bk0}), 9'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07: parity bit 0 is wrong, parity bit 1 is right
        po = 1'b0;
        send_frame(0, 9'h007, 1'b1, 2'b11, 2 * OS0);
        lit("par_bad", 9'(pe0), 9'd1);
        send_frame(0, 9'h007, 1'b0, 2'b11, 2 * OS0);
        lit("par_good", 9'(pe0), 9'd0);
`endif

        // Random frames, tick every clk, then ticks gated to one clk in three
        for (int i = 0; i < 50; i++) begin
            if (i == 40) div = 3;
            po = 1'($urandom_range(0, 1));
            rd = 9'($urandom);
            rs = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 9) == 0) begin
                rd = '0;
                rs = 2'b00;
            end
            send_frame(0, rd, ($urandom_range(0, 3) == 0), rs, $urandom_range(4, 2 * OS0 * div));
        end
        div = 1;
        drive(0, 1'b1, 4 * OS0);

        // 7-bit, two stop bits, second stop low
        drive(1, 1'b1, 4);
        send_frame(1, 9'h055, 1'b0, 2'b01, 2 * OS1);
        lit("d7s2_dout", 9'(dout1), 9'h055);
        lit("d7s2_ferr", 9'(fe1), 9'd1);

        // Reset during the data bits of the next frame aborts it
        drive(1, 1'b0, OS1);
        drive(1, 1'b1, OS1);
        drive(1, 1'b0, OS1);
        rstn1 = 1'b0;
        rx1 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        lit("rst_dout", 9'(dout1), 9'h000);
        lit("rst_flags", 9'({done1, fe1, pe1, bk1, bz1}), 9'd0);
        rstn1 = 1'b1;
        drive(1, 1'b1, 4 * OS1);
        lit("rst_after_busy", 9'(bz1), 9'd0);
        lit("rst_after_dout", 9'(dout1), 9'h000);

        for (int i = 0; i < 30; i++) begin
            po = 1'($urandom_range(0, 1));
            rd = 9'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(1, rd, ($urandom_range(0, 3) == 0), rs, $urandom_range(4, 2 * OS1));
        end
        drive(1, 1'b1, 4 * OS1);

        lit("q0_drained", 9'(q0.size()), 9'd0);
        lit("q1_drained", 9'(q1.size()), 9'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
